// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register: captures one decoded instruction with forwarded
// register operands, resolves the immediate and SUB negation, and hands it to the ALU.
module id_ex_stage #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3,
   parameter bit          FWD_EN = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [7:0]        OPCODE,
   input  logic [ADDR_W-1:0] DEST,
   input  logic [DATA_W-1:0] IMM,
   input  logic [ADDR_W-1:0] READREG1,
   input  logic [ADDR_W-1:0] READREG2,
   input  logic [DATA_W-1:0] REGOUT1,
   input  logic [DATA_W-1:0] REGOUT2,
   input  logic              WB_EN,
   input  logic [ADDR_W-1:0] WB_REG,
   input  logic [DATA_W-1:0] WB_DATA,
   input  logic              FLUSH,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [2:0]        ALU_OP,
   output logic [DATA_W-1:0] DATA1,
   output logic [DATA_W-1:0] DATA2,
   output logic [ADDR_W-1:0] WR_DEST,
   output logic              WR_EN,
   output logic              ILLEGAL
);

   localparam int unsigned ALUOP_W = 3;
   localparam logic [ALUOP_W-1:0] ALU_FWD = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;

   logic               out_valid_q, out_valid_d;
   logic [ALUOP_W-1:0] alu_op_q,    alu_op_d;
   logic [DATA_W-1:0]  data1_q,     data1_d;
   logic [DATA_W-1:0]  data2_q,     data2_d;
   logic [ADDR_W-1:0]  wr_dest_q,   wr_dest_d;
   logic               wr_en_q,     wr_en_d;
   logic               illegal_q,   illegal_d;

   logic [DATA_W-1:0]  op1, op2, dec_data2;
   logic [ALUOP_W-1:0] dec_alu_op;
   logic               accept, legal;

   assign IN_READY = !FLUSH && (!out_valid_q || OUT_READY);
   assign accept   = IN_VALID && IN_READY;
   assign legal    = (OPCODE <= 8'd5);

   // Same-cycle writeback bypass around the register file
   always_comb begin
      op1 = REGOUT1;
      op2 = REGOUT2;
      if (FWD_EN && WB_EN && (WB_REG == READREG1)) op1 = WB_DATA;
      if (FWD_EN && WB_EN && (WB_REG == READREG2)) op2 = WB_DATA;
   end

   always_comb begin
      dec_alu_op = ALU_FWD;
      dec_data2  = op2;
      case (OPCODE)
         8'd0: dec_data2 = IMM;
         8'd2: dec_alu_op = ALU_ADD;
         8'd3: begin
            dec_alu_op = ALU_ADD;
            dec_data2  = ~op2 + DATA_W'(1);
         end
         8'd4: dec_alu_op = ALU_AND;
         8'd5: dec_alu_op = ALU_OR;
         default: ;
      endcase
   end

   // Illegal opcodes consume the slot but leave the held bundle untouched
   always_comb begin
      out_valid_d = out_valid_q;
      alu_op_d    = alu_op_q;
      data1_d     = data1_q;
      data2_d     = data2_q;
      wr_dest_d   = wr_dest_q;
      wr_en_d     = wr_en_q;
      illegal_d   = 1'b0;
      if (FLUSH) begin
         out_valid_d = 1'b0;
         wr_en_d     = 1'b0;
      end else begin
         if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
            wr_en_d     = 1'b0;
         end
         if (accept) begin
            if (legal) begin
               out_valid_d = 1'b1;
               wr_en_d     = 1'b1;
               alu_op_d    = dec_alu_op;
               data1_d     = op1;
               data2_d     = dec_data2;
               wr_dest_d   = DEST;
            end else begin
               illegal_d   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         out_valid_q <= 1'b0;
         alu_op_q    <= '0;
         data1_q     <= '0;
         data2_q     <= '0;
         wr_dest_q   <= '0;
         wr_en_q     <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         alu_op_q    <= alu_op_d;
         data1_q     <= data1_d;
         data2_q     <= data2_d;
         wr_dest_q   <= wr_dest_d;
         wr_en_q     <= wr_en_d;
         illegal_q   <= illegal_d;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign ALU_OP    = alu_op_q;
   assign DATA1     = data1_q;
   assign DATA2     = data2_q;
   assign WR_DEST   = wr_dest_q;
   assign WR_EN     = wr_en_q;
   assign ILLEGAL   = illegal_q;

endmodule
